// File: rtl/invsqrt_pkg.sv
// Shared definitions for the fast inverse-square-root pipeline: float field
// widths, classification codes and the default seed constant.
package invsqrt_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h5f3759df;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_ZERO = 2'd1;
    localparam logic [1:0] ERR_NEG  = 2'd2;
    localparam logic [1:0] ERR_INF  = 2'd3;

    typedef struct packed {
        logic [31:0] x2;
        logic [31:0] y;
        logic [1:0]  err_code;
        logic        denorm;
    } init_result_t;

    // Inf/NaN outranks zero, and zero outranks sign so that -0 reports as zero.
    function automatic logic [1:0] classify(input logic [31:0] value);
        logic [EXP_W-1:0] exp_f;
        logic [MAN_W-1:0] man_f;
        logic [1:0]       code;
        exp_f = value[30:23];
        man_f = value[22:0];
        if (exp_f == {EXP_W{1'b1}})
            code = ERR_INF;
        else if ({exp_f, man_f} == '0)
            code = ERR_ZERO;
        else if (value[31])
            code = ERR_NEG;
        else
            code = ERR_OK;
        return code;
    endfunction

endpackage

// File: rtl/invsqrt_init_fifo.sv
// Small synchronous FIFO with occupancy count; the caller qualifies push/pop
// so that it never pushes when full or pops when empty.
module invsqrt_init_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    pop_data,
    output logic [CNT_BITS-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/invsqrt_init_stage.sv
// Front stage of the inverse-square-root pipeline: classifies each operand,
// forms the seed and half-operand, and buffers results in a small FIFO.
module invsqrt_init_stage
    import invsqrt_pkg::*;
#(
    parameter logic [31:0] MAGIC = DEFAULT_MAGIC,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      number,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      x2,
    output logic [31:0]      y,
    output logic [1:0]       err_code,
    output logic             denorm,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam int ENTRY_W  = $bits(init_result_t) + TAG_W;

    logic [EXP_W-1:0]    exp_f;
    logic [MAN_W-1:0]    man_f;
    logic [31:0]         half_mag;
    init_result_t        result;
    logic                push;
    logic                pop;
    logic [CNT_BITS-1:0] fifo_count;
    logic [ENTRY_W-1:0]  head;
    init_result_t        head_result;

    assign exp_f    = number[30:23];
    assign man_f    = number[22:0];
    assign half_mag = {1'b0, number[30:1]};

    // Normal operands halve by decrementing the exponent; exp 0/1 shift the
    // magnitude instead, which stays exact apart from the dropped mantissa LSB.
    always_comb begin
        result          = '0;
        result.err_code = classify(number);
        if (result.err_code == ERR_OK) begin
            if (exp_f >= 8'd2)
                result.x2 = {1'b0, exp_f - 8'd1, man_f};
            else
                result.x2 = half_mag;
            result.y      = MAGIC - half_mag;
            result.denorm = (exp_f == '0) && (man_f != '0);
        end
    end

    // Ready depends only on the registered count, never on out_ready.
    assign in_ready  = fifo_count < CNT_BITS'(DEPTH);
    assign out_valid = fifo_count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    invsqrt_init_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({result, in_tag}),
        .pop      (pop),
        .pop_data (head),
        .count    (fifo_count)
    );

    assign head_result = head[ENTRY_W-1:TAG_W];
    assign out_tag     = head[TAG_W-1:0];
    assign x2          = head_result.x2;
    assign y           = head_result.y;
    assign err_code    = head_result.err_code;
    assign denorm      = head_result.denorm;

    // Clear takes priority over a same-cycle error push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (cnt_clr)
            err_cnt <= '0;
        else if (push && (result.err_code != ERR_OK) && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: tb/tb_invsqrt_init_stage.sv
// Scoreboard bench for invsqrt_init_stage: the driver queues expected results
// from a float-level reference model, a negedge monitor pops and compares them.
module tb_invsqrt_init_stage;

    localparam int TAG_W = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam logic [31:0] MAGIC = 32'h5f3759df;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      number;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;
    logic             cnt_clr;

    logic             in_ready, out_valid, denorm;
    logic [31:0]      x2, y;
    logic [1:0]       err_code;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] err_cnt;

    logic             s_in_ready, s_out_valid, s_denorm;
    logic [31:0]      s_x2, s_y;
    logic [1:0]       s_err_code;
    logic [TAG_W-1:0] s_out_tag;
    logic [1:0]       s_err_cnt;

    always #5 clk = ~clk;

    invsqrt_init_stage #(.MAGIC(MAGIC), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .number(number), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .x2(x2), .y(y), .err_code(err_code), .denorm(denorm), .out_tag(out_tag),
        .err_cnt(err_cnt), .cnt_clr(cnt_clr)
    );

    // Narrow-counter copy sharing all inputs, used for saturation checks.
    invsqrt_init_stage #(.MAGIC(MAGIC), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .number(number), .in_tag(in_tag), .out_valid(s_out_valid), .out_ready(out_ready),
        .x2(s_x2), .y(s_y), .err_code(s_err_code), .denorm(s_denorm), .out_tag(s_out_tag),
        .err_cnt(s_err_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [31:0]      x2;
        logic [31:0]      y;
        logic [1:0]       err;
        logic             denorm;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t held;
    logic held_v = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    int   model_sat = 0;

    // Reference: halve the magnitude arithmetically; normals halve via exponent.
    function automatic exp_t refModel(input logic [31:0] n, input logic [TAG_W-1:0] t);
        exp_t        r;
        int unsigned e;
        int unsigned mag;
        e        = n[30:23];
        mag      = n & 32'h7fffffff;
        r.tag    = t;
        r.x2     = 0;
        r.y      = 0;
        r.denorm = 1'b0;
        if (e == 255) r.err = 2'd3;
        else if (mag == 0) r.err = 2'd1;
        else if (n[31]) r.err = 2'd2;
        else begin
            r.err    = 2'd0;
            r.x2     = (e >= 2) ? (n - 32'h0080_0000) : (mag / 2);
            r.y      = MAGIC - (mag / 2);
            r.denorm = (e == 0);
        end
        return r;
    endfunction

    function automatic logic [31:0] randNormal();
        logic [31:0] v;
        v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        return v;
    endfunction

    function automatic logic [31:0] randAny();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = randNormal();
            1: v = $urandom;
            2: v = {1'($urandom), 31'd0};
            3: v = {1'($urandom), 8'd0, 23'($urandom_range(1, 32'h7fffff))};
            4: v = {1'($urandom), 8'hff, 23'($urandom)};
            default: v = {1'b0, 8'd1, 23'($urandom)};
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle; acceptance is known up front since in_ready is registered.
    task automatic applyStimulus(input logic v, input logic [31:0] n,
                                 input logic [TAG_W-1:0] t, input logic clr);
        exp_t e;
        in_valid = v;
        number   = n;
        in_tag   = t;
        cnt_clr  = clr;
        if (v && in_ready) begin
            e = refModel(n, t);
            sb.push_back(e);
            if (!clr && e.err != 2'd0) begin
                if (model_cnt < 65535) model_cnt++;
                if (model_sat < 3) model_sat++;
            end
        end
        if (clr) begin
            model_cnt = 0;
            model_sat = 0;
        end
        step();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        sb.delete();
        model_cnt = 0;
        model_sat = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int waited;
        out_ready = 1'b1;
        waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                checkOutput("hold_x2", x2, held.x2);
                checkOutput("hold_y", y, held.y);
                checkOutput("hold_tag", out_tag, held.tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("x2", x2, mon_e.x2);
                    checkOutput("y", y, mon_e.y);
                    checkOutput("err_code", err_code, mon_e.err);
                    checkOutput("denorm", denorm, mon_e.denorm);
                    checkOutput("out_tag", out_tag, mon_e.tag);
                end
            end
            held_v   = out_valid && !out_ready;
            held.x2  = x2;
            held.y   = y;
            held.tag = out_tag;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; number = '0; in_tag = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_x2", x2, 0);
        checkOutput("rst_y", y, 0);
        doReset();

        $display("[TB] directed latency and value checks");
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h40800000, 4'd3, 1'b0);
        checkOutput("latency_valid", out_valid, 1);
        applyStimulus(1'b1, 32'h3F800000, 4'd5, 1'b0);
        applyStimulus(1'b1, 32'h00000002, 4'd6, 1'b0);
        applyStimulus(1'b1, 32'h00800000, 4'd7, 1'b0);
        drain();

        $display("[TB] streaming 100 positive normals");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, randNormal(), 4'(i), 1'b0);
            checkOutput("stream_no_bubble", out_valid, 1);
            checkOutput("stream_in_ready", in_ready, 1);
        end
        drain();

        $display("[TB] classification and error counting");
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h00000000, 4'd1, 1'b0);
        applyStimulus(1'b1, 32'h80000000, 4'd2, 1'b0);
        applyStimulus(1'b1, 32'hC0000000, 4'd3, 1'b0);
        applyStimulus(1'b1, 32'h7F800000, 4'd4, 1'b0);
        applyStimulus(1'b1, 32'hFFC00000, 4'd5, 1'b0);
        drain();
        checkOutput("err_cnt_five", err_cnt, 5);
        checkOutput("err_cnt_sat", s_err_cnt, 3);
        applyStimulus(1'b1, 32'h80000000, 4'd8, 1'b1);
        checkOutput("err_cnt_clr", err_cnt, 0);
        checkOutput("err_cnt_sat_clr", s_err_cnt, 0);
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, randNormal(), 4'd9, 1'b0);
        applyStimulus(1'b1, randNormal(), 4'd10, 1'b0);
        checkOutput("full_in_ready", in_ready, 0);
        repeat (5) step();
        checkOutput("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        applyStimulus(1'b1, randNormal(), 4'd11, 1'b0);
        checkOutput("ready_after_pop", in_ready, 1);
        applyStimulus(1'b1, randNormal(), 4'd12, 1'b0);
        applyStimulus(1'b1, randNormal(), 4'd13, 1'b0);
        drain();

        $display("[TB] reset with buffered entries");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00000000, 4'd14, 1'b0);
        applyStimulus(1'b1, 32'h40800000, 4'd15, 1'b0);
        rst = 1'b1;
        sb.delete();
        model_cnt = 0;
        model_sat = 0;
        step();
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_err_cnt", err_cnt, 0);
        checkOutput("midrst_x2", x2, 0);
        rst = 1'b0;
        step();

        $display("[TB] random traffic with random backpressure");
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), randAny(), 4'($urandom), 1'b0);
        end
        drain();
        checkOutput("rand_err_cnt", err_cnt, model_cnt);
        checkOutput("rand_err_cnt_sat", s_err_cnt, model_sat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
